// File: rtl/trace_pkg.sv
// Shared types for the execution-trace buffer: FSM state encoding, entry layout, flag bits.
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam int FLAG_BRANCH = 1;
  localparam int FLAG_WE     = 0;

  localparam int ENTRY_XLEN = 32;

  // Reference layout of one trace entry at the default width; the RAM word uses the same field order.
  typedef struct packed {
    logic [ENTRY_XLEN-1:0] pc;
    logic [31:0]           instr;
    logic [ENTRY_XLEN-1:0] alu;
    logic [ENTRY_XLEN-1:0] wdata;
    logic [1:0]            flags;
  } entry_t;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: one write port, one read port with registered output.
module trace_ram #(
  parameter int WIDTH  = 130,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/exec_trace_buffer.sv
// Execution-trace capture: immediate or PC-triggered circular capture, frozen in DONE for readout.
// Build option EXEC_TRACE_FILTER_EN stores only branch/write-back samples (trigger sample always kept).
module exec_trace_buffer
  import trace_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              mode,
  input  logic [XLEN-1:0]   trig_pc,
  input  logic [ADDR_W:0]   post_count,
  input  logic              valid_in,
  input  logic [XLEN-1:0]   pc_in,
  input  logic [31:0]       instr_in,
  input  logic [XLEN-1:0]   alu_in,
  input  logic [XLEN-1:0]   wdata_in,
  input  logic              branch_in,
  input  logic              reg_we_in,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [XLEN-1:0]   rd_pc,
  output logic [31:0]       rd_instr,
  output logic [XLEN-1:0]   rd_alu,
  output logic [XLEN-1:0]   rd_wdata,
  output logic [1:0]        rd_flags,
  output logic [1:0]        state,
  output logic              done,
  output logic              wrapped,
  output logic [ADDR_W:0]   entry_count,
  output logic [ADDR_W-1:0] trig_index
);

  localparam int EW = 3*XLEN + 34;
  localparam logic [ADDR_W:0] FULL    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              wrapped_q, wrapped_d;
  logic              mode_q, mode_d;
  logic [XLEN-1:0]   trig_pc_q, trig_pc_d;
  logic [ADDR_W:0]   post_q, post_d;
  logic [ADDR_W:0]   remain_q, remain_d;
  logic [ADDR_W-1:0] trig_phys_q, trig_phys_d;
  logic [ADDR_W-1:0] trig_index_q, trig_index_d;
  logic              rd_valid_q, rd_valid_d;

  logic              we, keep, hit, go_done;
  logic [ADDR_W:0]   post_eff;
  logic [ADDR_W-1:0] oldest_q, oldest_d, rd_phys;
  logic [EW-1:0]     wr_word, rd_word;

`ifdef EXEC_TRACE_FILTER_EN
  assign keep = branch_in | reg_we_in;
`else
  assign keep = 1'b1;
`endif

  always_comb begin
    post_eff = post_count;
    if (post_count == '0)        post_eff = CNT_ONE;
    else if (post_count > FULL)  post_eff = FULL;
  end

  assign hit = (state_q == ARMED) && (pc_in == trig_pc_q);

  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    count_d      = count_q;
    wrapped_d    = wrapped_q;
    mode_d       = mode_q;
    trig_pc_d    = trig_pc_q;
    post_d       = post_q;
    remain_d     = remain_q;
    trig_phys_d  = trig_phys_q;
    trig_index_d = trig_index_q;
    we           = 1'b0;
    go_done      = 1'b0;
    oldest_d     = '0;

    if (arm) begin
      wptr_d       = '0;
      count_d      = '0;
      wrapped_d    = 1'b0;
      mode_d       = mode;
      trig_pc_d    = trig_pc;
      post_d       = post_eff;
      remain_d     = post_eff;
      trig_phys_d  = '0;
      trig_index_d = '0;
      state_d      = mode ? ARMED : CAPTURE;
    end else if (valid_in) begin
      unique case (state_q)
        ARMED: begin
          we = keep | hit;
          if (hit) begin
            trig_phys_d = wptr_q;
            remain_d    = post_q - CNT_ONE;
            if (post_q == CNT_ONE) go_done = 1'b1;
            else                   state_d = CAPTURE;
          end
        end
        CAPTURE: begin
          we = keep;
          if (keep) begin
            remain_d = remain_q - CNT_ONE;
            if (remain_q == CNT_ONE) go_done = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (we) begin
      wptr_d = wptr_q + 1'b1;
      if (count_q == FULL) wrapped_d = 1'b1;
      else                 count_d   = count_q + CNT_ONE;
    end

    // Trigger position is converted to a logical index against the final oldest pointer.
    if (go_done) begin
      state_d      = DONE;
      oldest_d     = (count_d == FULL) ? wptr_d : '0;
      trig_index_d = mode_q ? (trig_phys_d - oldest_d) : '0;
    end
  end

  assign oldest_q   = (count_q == FULL) ? wptr_q : '0;
  assign rd_phys    = oldest_q + rd_addr;
  assign rd_valid_d = ({1'b0, rd_addr} < count_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wptr_q       <= '0;
      count_q      <= '0;
      wrapped_q    <= 1'b0;
      mode_q       <= 1'b0;
      trig_pc_q    <= '0;
      post_q       <= CNT_ONE;
      remain_q     <= '0;
      trig_phys_q  <= '0;
      trig_index_q <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      count_q      <= count_d;
      wrapped_q    <= wrapped_d;
      mode_q       <= mode_d;
      trig_pc_q    <= trig_pc_d;
      post_q       <= post_d;
      remain_q     <= remain_d;
      trig_phys_q  <= trig_phys_d;
      trig_index_q <= trig_index_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  assign wr_word = {pc_in, instr_in, alu_in, wdata_in, branch_in, reg_we_in};

  trace_ram #(
    .WIDTH  (EW),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wptr_q),
    .wdata_i (wr_word),
    .raddr_i (rd_phys),
    .rdata_o (rd_word)
  );

  // RAM output is not reset; the registered valid bit masks it to zero.
  always_comb begin
    rd_pc    = '0;
    rd_instr = '0;
    rd_alu   = '0;
    rd_wdata = '0;
    rd_flags = '0;
    if (rd_valid_q) {rd_pc, rd_instr, rd_alu, rd_wdata, rd_flags} = rd_word;
  end

  assign state       = state_q;
  assign done        = (state_q == DONE);
  assign wrapped     = wrapped_q;
  assign entry_count = count_q;
  assign trig_index  = trig_index_q;

endmodule

// File: tb/tb_exec_trace_buffer.sv
// Directed self-checking bench for exec_trace_buffer (DEPTH=16, XLEN=32).
module tb_exec_trace_buffer;

  localparam int XLEN = 32;
  localparam int DEPTH = 16;
  localparam int AW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            arm;
  logic            mode;
  logic [XLEN-1:0] trig_pc;
  logic [AW:0]     post_count;
  logic            valid_in;
  logic [XLEN-1:0] pc_in;
  logic [31:0]     instr_in;
  logic [XLEN-1:0] alu_in;
  logic [XLEN-1:0] wdata_in;
  logic            branch_in;
  logic            reg_we_in;
  logic [AW-1:0]   rd_addr;
  logic [XLEN-1:0] rd_pc;
  logic [31:0]     rd_instr;
  logic [XLEN-1:0] rd_alu;
  logic [XLEN-1:0] rd_wdata;
  logic [1:0]      rd_flags;
  logic [1:0]      state;
  logic            done;
  logic            wrapped;
  logic [AW:0]     entry_count;
  logic [AW-1:0]   trig_index;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  exec_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .mode(mode), .trig_pc(trig_pc),
    .post_count(post_count), .valid_in(valid_in), .pc_in(pc_in),
    .instr_in(instr_in), .alu_in(alu_in), .wdata_in(wdata_in),
    .branch_in(branch_in), .reg_we_in(reg_we_in), .rd_addr(rd_addr),
    .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_alu(rd_alu), .rd_wdata(rd_wdata),
    .rd_flags(rd_flags), .state(state), .done(done), .wrapped(wrapped),
    .entry_count(entry_count), .trig_index(trig_index)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic m, input logic [31:0] tpc, input logic [AW:0] pc_cnt);
    arm = 1'b1; mode = m; trig_pc = tpc; post_count = pc_cnt;
    tick();
    arm = 1'b0;
  endtask

  task automatic sample(input logic [31:0] pc, input logic br, input logic rwe);
    valid_in = 1'b1; pc_in = pc; instr_in = pc ^ 32'hA5A5_0013;
    alu_in = pc + 32'd1; wdata_in = pc + 32'd2; branch_in = br; reg_we_in = rwe;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    rd_addr = a;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    rd(4'd0);
    n_vec++; if (state !== 2'd0)   begin n_err++; $display("FAIL reset_state got %0d exp 0", state); end
    n_vec++; if (done !== 1'b0)    begin n_err++; $display("FAIL reset_done got %0b exp 0", done); end
    n_vec++; if (wrapped !== 1'b0) begin n_err++; $display("FAIL reset_wrapped got %0b exp 0", wrapped); end
    n_vec++; if (entry_count !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", entry_count); end
    n_vec++; if (trig_index !== 4'd0)  begin n_err++; $display("FAIL reset_trig_index got %0d exp 0", trig_index); end
    n_vec++; if (rd_pc !== 32'd0)      begin n_err++; $display("FAIL reset_rd_pc got %h exp 0", rd_pc); end
  endtask

  task automatic test_immediate();
    do_arm(1'b0, 32'h0, 5'd4);
    n_vec++; if (state !== 2'd2) begin n_err++; $display("FAIL imm_start_state got %0d exp 2", state); end
    for (int i = 0; i < 6; i++) begin
      sample(32'(i * 4), i[0], 1'b1);
      if (i == 2) begin
        n_vec++; if (state !== 2'd2) begin n_err++; $display("FAIL imm_state_s3 got %0d exp 2", state); end
      end
      if (i == 3) begin
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL imm_done_s4 got %0b exp 1", done); end
      end
    end
    n_vec++; if (entry_count !== 5'd4) begin n_err++; $display("FAIL imm_count got %0d exp 4", entry_count); end
    n_vec++; if (wrapped !== 1'b0)     begin n_err++; $display("FAIL imm_wrapped got %0b exp 0", wrapped); end
    for (int a = 0; a < 4; a++) begin
      rd(4'(a));
      n_vec++; if (rd_pc !== 32'(a * 4)) begin n_err++; $display("FAIL imm_rd_pc[%0d] got %h exp %h", a, rd_pc, a * 4); end
    end
    rd(4'd1);
    n_vec++; if (rd_instr !== (32'h4 ^ 32'hA5A5_0013)) begin n_err++; $display("FAIL imm_rd_instr got %h exp %h", rd_instr, 32'h4 ^ 32'hA5A5_0013); end
    n_vec++; if (rd_alu !== 32'h5)   begin n_err++; $display("FAIL imm_rd_alu got %h exp 5", rd_alu); end
    n_vec++; if (rd_wdata !== 32'h6) begin n_err++; $display("FAIL imm_rd_wdata got %h exp 6", rd_wdata); end
    n_vec++; if (rd_flags !== 2'b11) begin n_err++; $display("FAIL imm_rd_flags got %b exp 11", rd_flags); end
    rd(4'd4);
    n_vec++; if (rd_pc !== 32'd0) begin n_err++; $display("FAIL imm_rd_beyond got %h exp 0", rd_pc); end
  endtask

  task automatic test_trigger();
    do_arm(1'b1, 32'h40, 5'd4);
    n_vec++; if (state !== 2'd1) begin n_err++; $display("FAIL trg_armed got %0d exp 1", state); end
    for (int i = 0; i < 20; i++) begin
      sample(32'(i * 4), 1'b0, 1'b1);
      if (i == 16) begin
        n_vec++; if (state !== 2'd2) begin n_err++; $display("FAIL trg_capture got %0d exp 2", state); end
      end
      if (i == 18) begin
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL trg_early_done got %0b exp 0", done); end
      end
    end
    n_vec++; if (state !== 2'd3)        begin n_err++; $display("FAIL trg_done_state got %0d exp 3", state); end
    sample(32'h50, 1'b0, 1'b1);
    n_vec++; if (wrapped !== 1'b1)      begin n_err++; $display("FAIL trg_wrapped got %0b exp 1", wrapped); end
    n_vec++; if (entry_count !== 5'd16) begin n_err++; $display("FAIL trg_count got %0d exp 16", entry_count); end
    n_vec++; if (trig_index !== 4'd12)  begin n_err++; $display("FAIL trg_index got %0d exp 12", trig_index); end
    rd(4'd0);
    n_vec++; if (rd_pc !== 32'h10) begin n_err++; $display("FAIL trg_rd0 got %h exp 10", rd_pc); end
    rd(4'd15);
    n_vec++; if (rd_pc !== 32'h4C) begin n_err++; $display("FAIL trg_rd15 got %h exp 4c", rd_pc); end
    rd(4'd12);
    n_vec++; if (rd_pc !== 32'h40) begin n_err++; $display("FAIL trg_rd_trig got %h exp 40", rd_pc); end
  endtask

  task automatic test_trigger_post0();
    do_arm(1'b1, 32'h40, 5'd0);
    for (int i = 0; i < 17; i++) sample(32'(i * 4), 1'b0, 1'b1);
    n_vec++; if (done !== 1'b1)        begin n_err++; $display("FAIL p0_done got %0b exp 1", done); end
    n_vec++; if (trig_index !== 4'd15) begin n_err++; $display("FAIL p0_index got %0d exp 15", trig_index); end
    n_vec++; if (wrapped !== 1'b1)     begin n_err++; $display("FAIL p0_wrapped got %0b exp 1", wrapped); end
    rd(4'd15);
    n_vec++; if (rd_pc !== 32'h40) begin n_err++; $display("FAIL p0_rd15 got %h exp 40", rd_pc); end
    rd(4'd0);
    n_vec++; if (rd_pc !== 32'h04) begin n_err++; $display("FAIL p0_rd0 got %h exp 04", rd_pc); end
  endtask

  task automatic test_arm_priority();
    do_arm(1'b0, 32'h0, 5'd4);
    sample(32'h0, 1'b0, 1'b1);
    sample(32'h4, 1'b0, 1'b1);
    valid_in = 1'b1; pc_in = 32'h08; branch_in = 1'b0; reg_we_in = 1'b1;
    do_arm(1'b1, 32'h100, 5'd4);
    valid_in = 1'b0;
    n_vec++; if (state !== 2'd1)       begin n_err++; $display("FAIL prio_state got %0d exp 1", state); end
    n_vec++; if (entry_count !== 5'd0) begin n_err++; $display("FAIL prio_count got %0d exp 0", entry_count); end
    valid_in = 1'b1; pc_in = 32'h0C;
    do_arm(1'b0, 32'h0, 5'd2);
    valid_in = 1'b0;
    n_vec++; if (state !== 2'd2)       begin n_err++; $display("FAIL prio_state2 got %0d exp 2", state); end
    n_vec++; if (entry_count !== 5'd0) begin n_err++; $display("FAIL prio_count2 got %0d exp 0", entry_count); end
  endtask

  task automatic test_reset_mid();
    do_arm(1'b0, 32'h0, 5'd8);
    for (int i = 0; i < 3; i++) sample(32'(i * 4), 1'b0, 1'b1);
    n_vec++; if (entry_count !== 5'd3) begin n_err++; $display("FAIL mid_pre_count got %0d exp 3", entry_count); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_vec++; if (state !== 2'd0)       begin n_err++; $display("FAIL mid_state got %0d exp 0", state); end
    n_vec++; if (entry_count !== 5'd0) begin n_err++; $display("FAIL mid_count got %0d exp 0", entry_count); end
    n_vec++; if (done !== 1'b0)        begin n_err++; $display("FAIL mid_done got %0b exp 0", done); end
    for (int a = 0; a < DEPTH; a++) begin
      rd(4'(a));
      n_vec++; if ({rd_pc, rd_instr, rd_alu, rd_wdata, rd_flags} !== '0) begin
        n_err++; $display("FAIL mid_rd[%0d] got pc %h exp 0", a, rd_pc);
      end
    end
    sample(32'h20, 1'b1, 1'b1);
    n_vec++; if (entry_count !== 5'd0) begin n_err++; $display("FAIL idle_ignore got %0d exp 0", entry_count); end
  endtask

`ifdef EXEC_TRACE_FILTER_EN
  task automatic test_filter();
    do_arm(1'b0, 32'h0, 5'd2);
    sample(32'h00, 1'b0, 1'b0);
    sample(32'h04, 1'b0, 1'b1);
    sample(32'h08, 1'b0, 1'b0);
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL flt_early_done got %0b exp 0", done); end
    sample(32'h0C, 1'b1, 1'b0);
    n_vec++; if (done !== 1'b1)        begin n_err++; $display("FAIL flt_done got %0b exp 1", done); end
    n_vec++; if (entry_count !== 5'd2) begin n_err++; $display("FAIL flt_count got %0d exp 2", entry_count); end
    rd(4'd0);
    n_vec++; if (rd_flags !== 2'b01 || rd_pc !== 32'h04) begin n_err++; $display("FAIL flt_rd0 got %b/%h exp 01/04", rd_flags, rd_pc); end
    rd(4'd1);
    n_vec++; if (rd_flags !== 2'b10 || rd_pc !== 32'h0C) begin n_err++; $display("FAIL flt_rd1 got %b/%h exp 10/0c", rd_flags, rd_pc); end
  endtask
`else
  task automatic test_filter();
    do_arm(1'b0, 32'h0, 5'd2);
    sample(32'h00, 1'b0, 1'b0);
    n_vec++; if (entry_count !== 5'd1) begin n_err++; $display("FAIL nf_count got %0d exp 1", entry_count); end
    sample(32'h04, 1'b0, 1'b1);
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL nf_done got %0b exp 1", done); end
    rd(4'd0);
    n_vec++; if (rd_flags !== 2'b00 || rd_pc !== 32'h00) begin n_err++; $display("FAIL nf_rd0 got %b/%h exp 00/00", rd_flags, rd_pc); end
  endtask
`endif

  task automatic test_clamp();
    do_arm(1'b0, 32'h0, 5'd31);
    for (int i = 0; i < 15; i++) sample(32'(i * 4), 1'b0, 1'b1);
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL clamp_early got %0b exp 0", done); end
    sample(32'h3C, 1'b0, 1'b1);
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL clamp_done got %0b exp 1", done); end
    n_vec++; if (wrapped !== 1'b0) begin n_err++; $display("FAIL clamp_wrapped got %0b exp 0", wrapped); end
  endtask

  initial begin
    rst_n = 1'b0; arm = 1'b0; mode = 1'b0; trig_pc = '0; post_count = '0;
    valid_in = 1'b0; pc_in = '0; instr_in = '0; alu_in = '0; wdata_in = '0;
    branch_in = 1'b0; reg_we_in = 1'b0; rd_addr = '0;
    test_reset();
    test_immediate();
    test_trigger();
    test_trigger_post0();
    test_arm_priority();
    test_reset_mid();
    test_filter();
    test_clamp();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
